// File: rtl/rotor_phase_tracker.sv
// ---------------------------------------------------------------------------
// rotor_phase_tracker
//
// Converts magnet-sensor transitions from a spinning display panel into an
// absolute row (angle) index. Each transition of `mag` marks one segment
// boundary. NUM_MAG segments make up one revolution, and each segment holds
// RPS = IMG_HEIGHT/NUM_MAG rows. The segment period is measured and
// IIR-averaged. Rows inside a segment are interpolated from that period. The
// row count is re-synchronised at every magnet edge, so interpolation error
// never builds up past one segment.
//
// Ports:
//   clk           in   clock
//   nReset        in   synchronous, active-low reset
//   mag           in   asynchronous magnet sensor; every transition is an event
//   offset        in   [ROW_W]  angular offset; sampled at revolution start
//   row           out  [ROW_W]  current display row
//   rowEven       out  [ROW_W]  row of the opposite panel face (row + H/2)
//   valid         out  timing locked; row is meaningful
//   index         out  one-cycle pulse when segment 0 begins
//   rowChange     out  request: a new row is on row/rowEven
//   rowChangeAck  in   consumer acknowledge
//   rowMiss       out  sticky: a new row arrived while a request was pending
//   timeoutErr    out  sticky: rotation stalled while locked
//   segPeriod     out  [CNT_W]  averaged segment period, clk cycles
//   dbg_state     out  [2]      FSM state (0 IDLE, 1 ACQ, 2 RUN)
//
// Handshake: rowChange rises on the same edge that row/rowEven take a new
// value and stays high until an edge samples rowChangeAck=1 with no new row
// at that edge. An ack while rowChange=0 is ignored. A new row on the same
// edge as an ack keeps rowChange high and is not a miss. A new row while
// rowChange is still high and unacknowledged sets rowMiss (sticky).
// ---------------------------------------------------------------------------
module rotor_phase_tracker #(
  parameter  int CLK_FREQ   = 50_000_000,
  parameter  int MIN_FPS    = 10,
  parameter  int IMG_HEIGHT = 256,
  parameter  int NUM_MAG    = 8,
  parameter  int AVG_SHIFT  = 2,
  localparam int ROW_W      = $clog2(IMG_HEIGHT),
  localparam int RPS        = IMG_HEIGHT / NUM_MAG,
  localparam int TIMEOUT    = 2 * CLK_FREQ / (MIN_FPS * NUM_MAG),
  localparam int CNT_W      = $clog2(TIMEOUT) + 1
) (
  input  logic             clk,
  input  logic             nReset,
  input  logic             mag,
  input  logic [ROW_W-1:0] offset,
  output logic [ROW_W-1:0] row,
  output logic [ROW_W-1:0] rowEven,
  output logic             valid,
  output logic             index,
  output logic             rowChange,
  input  logic             rowChangeAck,
  output logic             rowMiss,
  output logic             timeoutErr,
  output logic [CNT_W-1:0] segPeriod,
  output logic [1:0]       dbg_state
);

  // Segment index and sub-row widths, kept at least one bit wide so that
  // NUM_MAG == 1 or RPS == 1 still elaborate.
  localparam int SEG_W   = (NUM_MAG > 1) ? $clog2(NUM_MAG) : 1;
  localparam int SUB_W   = (RPS > 1) ? $clog2(RPS) : 1;
  localparam int STEP_SH = $clog2(RPS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACQ  = 2'd1,
    RUN  = 2'd2
  } state_t;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_t           state_q, state_d;
  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             prev_q, prev_d;
  logic [CNT_W-1:0] seg_cnt_q, seg_cnt_d;
  logic [SEG_W-1:0] seg_idx_q, seg_idx_d;
  logic [CNT_W-1:0] seg_period_q, seg_period_d;
  logic [CNT_W-1:0] step_cnt_q, step_cnt_d;
  logic [SUB_W-1:0] sub_row_q, sub_row_d;
  logic [ROW_W-1:0] off_q, off_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [ROW_W-1:0] row_even_q, row_even_d;
  logic             valid_q, valid_d;
  logic             index_q, index_d;
  logic             row_change_q, row_change_d;
  logic             row_miss_q, row_miss_d;
  logic             timeout_err_q, timeout_err_d;

  // -------------------------------------------------------------------------
  // Combinational helpers
  // -------------------------------------------------------------------------
  logic               mag_change;
  logic [SEG_W-1:0]   seg_nxt;
  logic [CNT_W-1:0]   measured;
  logic [CNT_W-1:0]   step;
  logic               timeout_hit;
  logic signed [CNT_W:0] avg_diff;
  logic signed [CNT_W:0] avg_adj;
  logic signed [CNT_W:0] avg_sum;
  logic [ROW_W-1:0]   angle;
  logic               new_row;

  // The third flop holds the previous synchronised sample. The event is
  // acted on at the third clock edge after the pin moved.
  assign mag_change = sync2_q ^ prev_q;

  // seg_cnt counts edges since the last event, so the number of cycles
  // between two events is that count plus the event edge itself.
  assign measured = seg_cnt_q + CNT_W'(1);

  assign seg_nxt = (seg_idx_q == SEG_W'(NUM_MAG - 1)) ? '0
                                                     : seg_idx_q + SEG_W'(1);

  assign timeout_hit = (state_q != IDLE) && (seg_cnt_q == CNT_W'(TIMEOUT));

  // Cycles per row inside a segment. Never zero, or the sub-row would race.
  always_comb begin
    step = seg_period_q >> STEP_SH;
    if (step == '0) begin
      step = CNT_W'(1);
    end
  end

  // IIR update in signed arithmetic one bit wider, so a shorter new period
  // pulls the average down (arithmetic shift floors toward -inf).
  always_comb begin
    avg_diff = $signed({1'b0, measured}) - $signed({1'b0, seg_period_q});
    avg_adj  = avg_diff >>> AVG_SHIFT;
    avg_sum  = $signed({1'b0, seg_period_q}) + avg_adj;
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    sync1_d       = mag;
    sync2_d       = sync1_q;
    prev_d        = sync2_q;
    seg_cnt_d     = seg_cnt_q;
    seg_idx_d     = seg_idx_q;
    seg_period_d  = seg_period_q;
    step_cnt_d    = step_cnt_q;
    sub_row_d     = sub_row_q;
    off_d         = off_q;
    valid_d       = valid_q;
    index_d       = 1'b0;
    row_change_d  = row_change_q;
    row_miss_d    = row_miss_q;
    timeout_err_d = timeout_err_q;
    angle         = '0;
    row_d         = '0;
    row_even_d    = ROW_W'(IMG_HEIGHT / 2);
    new_row       = 1'b0;

    // Segment counter and index run in every state.
    if (mag_change) begin
      seg_cnt_d = '0;
      seg_idx_d = seg_nxt;
    end else if (seg_cnt_q != CNT_W'(TIMEOUT)) begin
      seg_cnt_d = seg_cnt_q + CNT_W'(1);
    end

    // Revolution start. The offset is taken only here, so a new offset
    // never makes the image jump mid-revolution.
    if (mag_change && (seg_nxt == '0)) begin
      index_d = 1'b1;
      off_d   = offset;
    end

    // Lock FSM
    if (timeout_hit) begin
      state_d = IDLE;
      if (state_q == RUN) begin
        timeout_err_d = 1'b1;
        valid_d       = 1'b0;
      end
    end else if (mag_change) begin
      unique case (state_q)
        IDLE: begin
          state_d = ACQ;
        end
        ACQ: begin
          seg_period_d = measured;
          state_d      = RUN;
          valid_d      = 1'b1;
          off_d        = offset;
        end
        RUN: begin
          seg_period_d = CNT_W'(avg_sum);
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    // Row interpolation. Every magnet edge restarts the segment at sub-row 0.
    // The sub-row then advances every `step` cycles and stops at the last
    // row of the segment if the next edge is late.
    if (state_d == RUN) begin
      if (mag_change) begin
        sub_row_d  = '0;
        step_cnt_d = CNT_W'(1);
      end else if (step_cnt_q >= step) begin
        step_cnt_d = CNT_W'(1);
        if (sub_row_q != SUB_W'(RPS - 1)) begin
          sub_row_d = sub_row_q + SUB_W'(1);
        end
      end else begin
        step_cnt_d = step_cnt_q + CNT_W'(1);
      end

      angle      = (ROW_W'(seg_idx_d) << STEP_SH) + ROW_W'(sub_row_d);
      row_d      = angle + off_d;
      row_even_d = row_d + ROW_W'(IMG_HEIGHT / 2);
      new_row    = (row_d != row_q);
    end else begin
      sub_row_d  = '0;
      step_cnt_d = '0;
    end

    // Request/acknowledge towards the frame-buffer fetch
    if (new_row) begin
      row_change_d = 1'b1;
      if (row_change_q && !rowChangeAck) begin
        row_miss_d = 1'b1;
      end
    end else if (rowChangeAck && row_change_q) begin
      row_change_d = 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!nReset) begin
      // Preload the synchroniser with the live pin level so leaving reset
      // never reports a spurious transition.
      state_q       <= IDLE;
      sync1_q       <= mag;
      sync2_q       <= mag;
      prev_q        <= mag;
      seg_cnt_q     <= '0;
      seg_idx_q     <= SEG_W'(NUM_MAG - 1);
      seg_period_q  <= '0;
      step_cnt_q    <= '0;
      sub_row_q     <= '0;
      off_q         <= '0;
      row_q         <= '0;
      row_even_q    <= ROW_W'(IMG_HEIGHT / 2);
      valid_q       <= 1'b0;
      index_q       <= 1'b0;
      row_change_q  <= 1'b0;
      row_miss_q    <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      prev_q        <= prev_d;
      seg_cnt_q     <= seg_cnt_d;
      seg_idx_q     <= seg_idx_d;
      seg_period_q  <= seg_period_d;
      step_cnt_q    <= step_cnt_d;
      sub_row_q     <= sub_row_d;
      off_q         <= off_d;
      row_q         <= row_d;
      row_even_q    <= row_even_d;
      valid_q       <= valid_d;
      index_q       <= index_d;
      row_change_q  <= row_change_d;
      row_miss_q    <= row_miss_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign row        = row_q;
  assign rowEven    = row_even_q;
  assign valid      = valid_q;
  assign index      = index_q;
  assign rowChange  = row_change_q;
  assign rowMiss    = row_miss_q;
  assign timeoutErr = timeout_err_q;
  assign segPeriod  = seg_period_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_rotor_phase_tracker.sv
// ---------------------------------------------------------------------------
// Bench for rotor_phase_tracker (CLK_FREQ=1 MHz, MIN_FPS=10, 64 rows,
// 8 magnets, AVG_SHIFT=2 -> TIMEOUT=25000, RPS=8).
// A reference model inside the bench derives row, period and handshake
// values from elapsed time since the last magnet event. A compare process
// checks every output on every falling edge. Hand-computed checks pin the
// model at key points.
// ---------------------------------------------------------------------------
module tb_rotor_phase_tracker;

  localparam int CLK_FREQ   = 1_000_000;
  localparam int MIN_FPS    = 10;
  localparam int IMG_HEIGHT = 64;
  localparam int NUM_MAG    = 8;
  localparam int AVG_SHIFT  = 2;
  localparam int RPS        = 8;
  localparam int TIMEOUT    = 25000;
  localparam int CNT_W      = 16;
  localparam int ROW_W      = 6;

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             nReset;
  logic             mag;
  logic [ROW_W-1:0] offset;
  logic             row_change_ack;

  logic [ROW_W-1:0] row;
  logic [ROW_W-1:0] row_even;
  logic             valid;
  logic             index;
  logic             row_change;
  logic             row_miss;
  logic             timeout_err;
  logic [CNT_W-1:0] seg_period;
  logic [1:0]       dbg_state;

  always #5 clk = ~clk;

  rotor_phase_tracker #(
    .CLK_FREQ  (CLK_FREQ),
    .MIN_FPS   (MIN_FPS),
    .IMG_HEIGHT(IMG_HEIGHT),
    .NUM_MAG   (NUM_MAG),
    .AVG_SHIFT (AVG_SHIFT)
  ) dut (
    .clk         (clk),
    .nReset      (nReset),
    .mag         (mag),
    .offset      (offset),
    .row         (row),
    .rowEven     (row_even),
    .valid       (valid),
    .index       (index),
    .rowChange   (row_change),
    .rowChangeAck(row_change_ack),
    .rowMiss     (row_miss),
    .timeoutErr  (timeout_err),
    .segPeriod   (seg_period),
    .dbg_state   (dbg_state)
  );

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Model state after each rising edge. The row is derived from elapsed
  // cycles since the segment started: sub-row = min(RPS-1, since / step).
  bit m_ready = 1'b0;
  bit h0, h1, h2;          // mag samples: newest, 1 edge old, 2 edges old
  int m_state;             // 0 idle, 1 acquiring, 2 running
  int m_cnt, m_seg, m_period, m_since, m_row, m_off;
  bit m_valid, m_terr, m_index, m_rc, m_miss;

  always @(posedge clk) begin : model
    bit ev, tmo, chg;
    int meas, d, step, sub, nrow;
    if (!nReset) begin
      h0 = mag; h1 = mag; h2 = mag;
      m_state = 0; m_cnt = 0; m_seg = NUM_MAG - 1; m_period = 0;
      m_since = 0; m_row = 0; m_off = 0;
      m_valid = 0; m_terr = 0; m_index = 0; m_rc = 0; m_miss = 0;
      m_ready = 1;
    end else begin
      // A pin transition is acted upon at the third edge that follows it.
      ev = (h1 != h2);
      h2 = h1; h1 = h0; h0 = mag;
      meas = m_cnt + 1;
      tmo  = (m_state != 0) && (m_cnt == TIMEOUT);
      m_index = 0;
      if (ev) begin
        m_seg = (m_seg + 1) % NUM_MAG;
        if (m_seg == 0) begin
          m_index = 1;
          m_off   = offset;
        end
      end
      if (tmo) begin
        if (m_state == 2) begin
          m_terr  = 1;
          m_valid = 0;
        end
        m_state = 0;
      end else if (ev) begin
        if (m_state == 0) begin
          m_state = 1;
        end else if (m_state == 1) begin
          m_period = meas;
          m_state  = 2;
          m_valid  = 1;
          m_off    = offset;
        end else begin
          d = meas - m_period;
          m_period = (m_period + (d >>> AVG_SHIFT)) % (1 << CNT_W);
        end
      end
      if (ev) m_cnt = 0;
      else if (m_cnt < TIMEOUT) m_cnt = m_cnt + 1;

      chg = 0;
      if (m_state == 2) begin
        if (ev) m_since = 0;
        else if (m_since < TIMEOUT) m_since = m_since + 1;
        step = m_period / RPS;
        if (step < 1) step = 1;
        sub = m_since / step;
        if (sub > RPS - 1) sub = RPS - 1;
        nrow = (m_seg * RPS + sub + m_off) % IMG_HEIGHT;
        chg = (nrow != m_row);
        m_row = nrow;
      end else begin
        m_since = 0;
        m_row   = 0;
      end

      if (chg) begin
        if (m_rc && !row_change_ack) m_miss = 1;
        m_rc = 1;
      end else if (row_change_ack) begin
        m_rc = 0;
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (m_ready) begin
      check("valid",      valid,       m_valid);
      check("row",        row,         m_row);
      check("rowEven",    row_even,    (m_row + IMG_HEIGHT / 2) % IMG_HEIGHT);
      check("index",      index,       m_index);
      check("rowChange",  row_change,  m_rc);
      check("rowMiss",    row_miss,    m_miss);
      check("timeoutErr", timeout_err, m_terr);
      check("segPeriod",  seg_period,  m_period);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Toggle the magnet, then let n cycles pass.
  task automatic seg(input int n);
    mag = ~mag;
    tick(n);
  endtask

  // Toggle, then n cycles with a random acknowledge each cycle.
  task automatic seg_rand(input int n);
    mag = ~mag;
    for (int i = 0; i < n; i++) begin
      row_change_ack = ($urandom_range(0, 3) != 0);
      tick(1);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    nReset = 1'b0;
    mag = 1'b1;
    offset = '0;
    row_change_ack = 1'b0;

    // Reset with mag high, then idle: nothing may happen.
    tick(5);
    nReset = 1'b1;
    tick(100);
    check("rst_valid",   valid,       0);
    check("rst_row",     row,         0);
    check("rst_rowEven", row_even,    32);
    check("rst_period",  seg_period,  0);
    check("rst_rc",      row_change,  0);
    check("rst_terr",    timeout_err, 0);

    // Lock on an 800-cycle rotation with ack tied high.
    row_change_ack = 1'b1;
    mag = ~mag; tick(3);                    // T1: seg 0, start of acquisition
    check("t1_index", index, 1);
    check("t1_valid", valid, 0);
    tick(797);
    mag = ~mag; tick(2);                    // T2
    check("lock_early", valid, 0);
    tick(1);
    check("lock_valid",   valid,      1);
    check("lock_period",  seg_period, 800);
    check("lock_row",     row,        8);
    check("lock_rowEven", row_even,   40);
    tick(150);
    check("step_row", row, 9);
    tick(647);

    seg(800);                               // T3: seg 2
    mag = ~mag; tick(400);                  // T4: seg 3, offset changes mid-rev
    offset = 6'd5;
    tick(400);
    mag = ~mag; tick(3);                    // T5: seg 4, offset not yet applied
    check("off_held", row, 32);
    tick(797);
    seg(800); seg(800); seg(800);           // T6..T8: seg 5..7
    mag = ~mag; tick(3);                    // T9: seg 0, offset taken
    check("idx_pulse",  index,      1);
    check("idx_row",    row,        5);
    check("idx_even",   row_even,   37);
    check("idx_rc",     row_change, 1);
    tick(1);
    check("idx_ack",    row_change, 0);
    tick(796);
    for (int i = 0; i < 6; i++) seg(800);   // T10..T15: seg 1..6
    mag = ~mag; tick(203);                  // T16: seg 7
    check("wrap_63", row, 63);
    tick(100);
    check("wrap_0",    row,      0);
    check("wrap_even", row_even, 32);
    tick(497);

    // Late edge: sub-row saturates at 7 until the edge arrives.
    mag = ~mag; tick(703);                  // T17: seg 0, period 900
    check("sat_row7", row, 12);
    tick(150);
    check("sat_hold", row, 12);
    tick(47);
    mag = ~mag; tick(3);                    // T18: seg 1, period 400 follows
    check("avg_900",  seg_period, 825);
    check("seg_base", row,        13);
    tick(397);
    mag = ~mag; tick(3);                    // T19: seg 2
    check("avg_400", seg_period, 718);
    check("pre_miss", row_miss, 0);

    // Withhold the acknowledge across a second row change.
    row_change_ack = 1'b0;
    tick(100);
    check("miss_rc",   row_change, 1);
    check("miss_flag", row_miss,   1);
    row_change_ack = 1'b1;
    tick(1);
    check("miss_ack",    row_change, 0);
    check("miss_sticky", row_miss,   1);
    tick(696);

    // Randomised rotation, acknowledge and offset.
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 2) == 0) offset = 6'($urandom_range(0, 63));
      seg_rand($urandom_range(20, 1200));
    end

    // Stall: the last edge starts the timeout window.
    row_change_ack = 1'b1;
    mag = ~mag; tick(3);
    tick(TIMEOUT);
    check("tmo_before", valid,       1);
    check("tmo_noerr",  timeout_err, 0);
    tick(1);
    check("tmo_valid",  valid,       0);
    check("tmo_err",    timeout_err, 1);
    check("tmo_row",    row,         0);
    check("tmo_even",   row_even,    32);

    // Reset while running clears the sticky flags.
    nReset = 1'b0;
    tick(1);
    check("mrst_terr",   timeout_err, 0);
    check("mrst_period", seg_period,  0);
    nReset = 1'b1;
    tick(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
